// File: rtl/mux_skid_buffer.sv
// Source-select mux feeding a two-entry head/skid FIFO with flush and an accepted-beat counter.
// The upstream ready signal depends only on registered occupancy and reset, so it never waits on out_ready.
module mux_skid_buffer #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*WIDTH-1:0]  in_data,
  input  logic [SELW-1:0]        sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_sel,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [15:0]            xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  head_data;
  logic [SELW-1:0]   head_sel;
  logic              head_err;
  logic [WIDTH-1:0]  skid_data;
  logic [SELW-1:0]   skid_sel;
  logic              skid_err;

  logic [WIDTH-1:0]  sel_word;
  logic              sel_err;
  logic              push;
  logic              pop;

  // A select with no matching source leaves the word zero and flags the error.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state != FULL) && !reset;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = head_data;
  assign out_sel   = head_sel;
  assign out_err   = head_err;

  // Head keeps its contents after the last pop so the outputs hold while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      head_data <= '0;
      head_sel  <= '0;
      head_err  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (push && !flush) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (flush) begin
        state     <= EMPTY;
        head_data <= '0;
        head_sel  <= '0;
        head_err  <= 1'b0;
        skid_data <= '0;
        skid_sel  <= '0;
        skid_err  <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              head_data <= sel_word;
              head_sel  <= sel;
              head_err  <= sel_err;
              state     <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_data <= sel_word;
              head_sel  <= sel;
              head_err  <= sel_err;
            end else if (push) begin
              skid_data <= sel_word;
              skid_sel  <= sel;
              skid_err  <= sel_err;
              state     <= FULL;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              head_data <= skid_data;
              head_sel  <= skid_sel;
              head_err  <= skid_err;
              state     <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_skid_buffer.sv
// Bench for mux_skid_buffer: a queue model checked every cycle, plus directed literal checks.
// A second instance with three sources shares the stimulus to exercise the out-of-range select.
module tb_mux_skid_buffer;

  logic         clk;
  logic         reset;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         flush;
  logic         out_ready;

  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err;
  logic         out_valid;
  logic [1:0]   occupancy;
  logic [15:0]  xfer_cnt;

  logic         in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3;
  logic         out_valid3;
  logic [1:0]   occupancy3;
  logic [15:0]  xfer_cnt3;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  mux_skid_buffer #(.WIDTH(32), .NSRC(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .xfer_cnt(xfer_cnt)
  );

  mux_skid_buffer #(.WIDTH(32), .NSRC(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
    .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready),
    .occupancy(occupancy3), .xfer_cnt(xfer_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  s;
    logic        e3;
    logic [31:0] w3;
    logic        e4;
    logic [31:0] w4;
  } entry_t;

  entry_t      q[$];
  entry_t      shown = '0;
  logic [15:0] mcnt = '0;

  function automatic entry_t makeEntry(input logic [127:0] d, input logic [1:0] s);
    entry_t      e;
    logic [127:0] sh;
    sh   = d >> (32 * s);
    e.s  = s;
    e.w4 = sh[31:0];
    e.e4 = 1'b0;
    if (s < 2'd3) begin
      e.w3 = sh[31:0];
      e.e3 = 1'b0;
    end else begin
      e.w3 = '0;
      e.e3 = 1'b1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic rdy, input logic fl);
    in_valid  = v;
    sel       = s;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of at most two entries; the shown entry is whatever was last at the front.
  always @(posedge clk) begin : model
    bit     acc;
    bit     pp;
    entry_t e;
    acc = in_valid && (q.size() < 2) && !reset;
    pp  = (q.size() != 0) && out_ready;
    e   = makeEntry(in_data, sel);
    if (reset) begin
      q.delete();
      shown = '0;
      mcnt  = '0;
    end else if (flush) begin
      q.delete();
      shown = '0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        mcnt = mcnt + 16'd1;
      end
    end
    if (q.size() != 0) shown = q[0];
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready",   32'(in_ready),  32'((q.size() < 2) && !reset));
      checkOutput("out_valid",  32'(out_valid), 32'(q.size() != 0));
      checkOutput("occupancy",  32'(occupancy), 32'(q.size()));
      checkOutput("xfer_cnt",   32'(xfer_cnt),  32'(mcnt));
      checkOutput("out_data",   out_data,       shown.w4);
      checkOutput("out_sel",    32'(out_sel),   32'(shown.s));
      checkOutput("out_err",    32'(out_err),   32'(shown.e4));
      checkOutput("out_data3",  out_data3,      shown.w3);
      checkOutput("out_sel3",   32'(out_sel3),  32'(shown.s));
      checkOutput("out_err3",   32'(out_err3),  32'(shown.e3));
    end
  end

  localparam logic [127:0] BASE = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  initial begin
    reset     = 1'b1;
    in_data   = BASE;
    sel       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    check_en = 1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'h0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data",  out_data,       32'h0);
    checkOutput("rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
    reset = 1'b0;

    // Basic select
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    checkOutput("basic_data", out_data,       32'h33333333);
    checkOutput("basic_sel",  32'(out_sel),   32'd2);
    checkOutput("basic_err",  32'(out_err),   32'd0);
    checkOutput("basic_cnt",  32'(xfer_cnt),  32'd1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("hold_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_data",  out_data,       32'h33333333);

    // Out-of-range select on the three-source instance
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    checkOutput("oor_data4", out_data,       32'h44444444);
    checkOutput("oor_data3", out_data3,      32'h0);
    checkOutput("oor_err3",  32'(out_err3),  32'd1);
    checkOutput("oor_sel3",  32'(out_sel3),  32'd3);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    // Backpressure: A, B fill the buffer, C waits at the input
    in_data[31:0] = 32'hAAAA0001;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    in_data[31:0] = 32'hBBBB0002;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("bp_occ",   32'(occupancy), 32'd2);
    checkOutput("bp_ready", 32'(in_ready),  32'd0);
    in_data[31:0] = 32'hCCCC0003;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
      checkOutput("bp_stall_data", out_data,      32'hAAAA0001);
      checkOutput("bp_stall_occ",  32'(occupancy), 32'd2);
    end
    checkOutput("bp_cnt", 32'(xfer_cnt), 32'd4);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_second", out_data,       32'hBBBB0002);
    checkOutput("bp_occ1",   32'(occupancy), 32'd1);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_third",  out_data,       32'hCCCC0003);
    checkOutput("bp_cnt2",   32'(xfer_cnt),  32'd5);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_empty",  32'(occupancy), 32'd0);

    // Streaming: one beat per cycle with occupancy pinned at one
    for (int i = 0; i < 8; i++) begin
      in_data[31:0] = 32'h100 + 32'(i);
      applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
      checkOutput("stream_occ",  32'(occupancy), 32'd1);
      checkOutput("stream_data", out_data,       32'h100 + 32'(i));
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("stream_cnt", 32'(xfer_cnt), 32'd13);

    // Flush at FULL with a beat offered, then flush with a real accept and pop
    in_data = BASE;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("fl_pre_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("fl_occ",   32'(occupancy), 32'd0);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_data",  out_data,       32'h0);
    checkOutput("fl_sel",   32'(out_sel),   32'd0);
    checkOutput("fl_cnt",   32'(xfer_cnt),  32'd15);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b1);
    checkOutput("fl2_occ",  32'(occupancy), 32'd0);
    checkOutput("fl2_cnt",  32'(xfer_cnt),  32'd16);

    // Counter wrap after 65536 accepts, then reset mid-stream
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b1, 1'b0);
    end
    checkOutput("wrap_cnt", 32'(xfer_cnt),  32'd0);
    checkOutput("wrap_occ", 32'(occupancy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("rst_mid_occ",   32'(occupancy), 32'd0);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_data",  out_data,       32'h0);
    checkOutput("rst_mid_err",   32'(out_err),   32'd0);
    checkOutput("rst_mid_cnt",   32'(xfer_cnt),  32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("first_acc_cnt",  32'(xfer_cnt), 32'd1);
    checkOutput("first_acc_data", out_data,      32'h22222222);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
